// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER multi-cycle control unit: opcodes, ALU functions,
// datapath mux selects, FSM states and the bundled control word.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1001;

    localparam logic [1:0] SRCA_RS1     = 2'd0;
    localparam logic [1:0] SRCA_UIMM    = 2'd1;
    localparam logic [1:0] SRCA_NOT_RS1 = 2'd2;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IIMM = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_PC   = 3'd3;
    localparam logic [2:0] SRCB_CSR  = 3'd4;

    localparam logic [2:0] PC_PLUS4  = 3'd0;
    localparam logic [2:0] PC_JALR   = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_JAL    = 3'd3;
    localparam logic [2:0] PC_MTVEC  = 3'd4;
    localparam logic [2:0] PC_MEPC   = 3'd5;

    localparam logic [1:0] RF_PC4 = 2'd0;
    localparam logic [1:0] RF_CSR = 2'd1;
    localparam logic [1:0] RF_MEM = 2'd2;
    localparam logic [1:0] RF_ALU = 2'd3;

    localparam logic [11:0] MRET_FUNCT12 = 12'h302;

    typedef logic [2:0] state_t;
    localparam state_t ST_INIT      = 3'd0;
    localparam state_t ST_FETCH     = 3'd1;
    localparam state_t ST_EXEC      = 3'd2;
    localparam state_t ST_WRITEBACK = 3'd3;
    localparam state_t ST_INTR      = 3'd4;

    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_we2;
        logic       mem_rden1;
        logic       mem_rden2;
        logic [3:0] alu_fun;
        logic [1:0] alu_srcA_sel;
        logic [2:0] alu_srcB_sel;
        logic [2:0] pc_source;
        logic [1:0] rf_wr_sel;
        logic       csr_we;
        logic       int_taken;
        logic       mret_exec;
    } ctrl_t;

endpackage

// File: rtl/otter_ctrl_unit_if.sv
// Control-unit <-> datapath bundle: instruction/branch flags in, control strobes out.
interface otter_ctrl_unit_if;
    logic [31:0] ir;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic        intr;
    logic        pc_write;
    logic        reg_write;
    logic        mem_we2;
    logic        mem_rden1;
    logic        mem_rden2;
    logic [3:0]  alu_fun;
    logic [1:0]  alu_srcA_sel;
    logic [2:0]  alu_srcB_sel;
    logic [2:0]  pc_source;
    logic [1:0]  rf_wr_sel;
    logic        csr_we;
    logic        int_taken;
    logic        mret_exec;

    modport master (
        input  ir, br_eq, br_lt, br_ltu, intr,
        output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, alu_fun,
               alu_srcA_sel, alu_srcB_sel, pc_source, rf_wr_sel, csr_we,
               int_taken, mret_exec
    );

    modport slave (
        output ir, br_eq, br_lt, br_ltu, intr,
        input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, alu_fun,
               alu_srcA_sel, alu_srcB_sel, pc_source, rf_wr_sel, csr_we,
               int_taken, mret_exec
    );
endinterface

// File: rtl/otter_cu_decoder.sv
// Pure combinational decode of an RV32I instruction into the control word used in EXEC.
module otter_cu_decoder
    import otter_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output ctrl_t       ctrl
);

    logic [2:0] funct3;
    logic       br_taken;
    logic       unused_ir_bits;

    assign funct3         = ir[14:12];
    assign unused_ir_bits = ^{ir[19:15], ir[11:7]};

    always_comb begin
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = ~br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = ~br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = ~br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Every non-load instruction finishes in EXEC, so pc_write defaults high and
    // unknown encodings fall out as a plain pc+4 NOP.
    always_comb begin
        ctrl          = '0;
        ctrl.pc_write = 1'b1;
        case (ir[6:0])
            OP_LOAD: begin
                ctrl.pc_write     = 1'b0;
                ctrl.mem_rden2    = 1'b1;
                ctrl.alu_fun      = ALU_ADD;
                ctrl.alu_srcB_sel = SRCB_IIMM;
            end
            OP_REG: begin
                ctrl.alu_fun   = {ir[30], funct3};
                ctrl.reg_write = 1'b1;
                ctrl.rf_wr_sel = RF_ALU;
            end
            OP_IMM: begin
                ctrl.alu_fun      = {ir[30] & (funct3 == 3'b101), funct3};
                ctrl.alu_srcB_sel = SRCB_IIMM;
                ctrl.reg_write    = 1'b1;
                ctrl.rf_wr_sel    = RF_ALU;
            end
            OP_LUI: begin
                ctrl.alu_fun      = ALU_LUI;
                ctrl.alu_srcA_sel = SRCA_UIMM;
                ctrl.reg_write    = 1'b1;
                ctrl.rf_wr_sel    = RF_ALU;
            end
            OP_AUIPC: begin
                ctrl.alu_fun      = ALU_ADD;
                ctrl.alu_srcA_sel = SRCA_UIMM;
                ctrl.alu_srcB_sel = SRCB_PC;
                ctrl.reg_write    = 1'b1;
                ctrl.rf_wr_sel    = RF_ALU;
            end
            OP_STORE: begin
                ctrl.alu_fun      = ALU_ADD;
                ctrl.alu_srcB_sel = SRCB_SIMM;
                ctrl.mem_we2      = 1'b1;
            end
            OP_JAL: begin
                ctrl.pc_source = PC_JAL;
                ctrl.reg_write = 1'b1;
                ctrl.rf_wr_sel = RF_PC4;
            end
            OP_JALR: begin
                ctrl.pc_source = PC_JALR;
                ctrl.reg_write = 1'b1;
                ctrl.rf_wr_sel = RF_PC4;
            end
            OP_BRANCH: begin
                ctrl.pc_source = br_taken ? PC_BRANCH : PC_PLUS4;
            end
            OP_SYSTEM: begin
                case (funct3)
                    3'b000: begin
                        if (ir[31:20] == MRET_FUNCT12) begin
                            ctrl.pc_source = PC_MEPC;
                            ctrl.mret_exec = 1'b1;
                        end
                    end
                    3'b001, 3'b010, 3'b011: begin
                        ctrl.csr_we    = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.rf_wr_sel = RF_CSR;
                        if (funct3 == 3'b001) begin
                            ctrl.alu_fun = ALU_LUI;
                        end else if (funct3 == 3'b010) begin
                            ctrl.alu_fun      = ALU_OR;
                            ctrl.alu_srcB_sel = SRCB_CSR;
                        end else begin
                            ctrl.alu_fun      = ALU_AND;
                            ctrl.alu_srcA_sel = SRCA_NOT_RS1;
                            ctrl.alu_srcB_sel = SRCB_CSR;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/otter_ctrl_unit.sv
// OTTER multi-cycle control unit: FETCH/EXEC/WRITEBACK sequencing with interrupt entry,
// driving datapath controls from the state and the decoded instruction.
module otter_ctrl_unit
    import otter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    otter_ctrl_unit_if.master bus
);

    state_t state;
    state_t next_state;
    ctrl_t  exec_ctrl;
    ctrl_t  ctrl;
    logic   is_load;

    otter_cu_decoder u_decoder (
        .ir     (bus.ir),
        .br_eq  (bus.br_eq),
        .br_lt  (bus.br_lt),
        .br_ltu (bus.br_ltu),
        .ctrl   (exec_ctrl)
    );

    assign is_load = (bus.ir[6:0] == OP_LOAD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // intr is only looked at in the last cycle of an instruction, so a request
    // arriving earlier simply waits for the instruction boundary.
    always_comb begin
        next_state = ST_INIT;
        case (state)
            ST_INIT:      next_state = ST_FETCH;
            ST_FETCH:     next_state = ST_EXEC;
            ST_EXEC: begin
                if (is_load) begin
                    next_state = ST_WRITEBACK;
                end else begin
                    next_state = bus.intr ? ST_INTR : ST_FETCH;
                end
            end
            ST_WRITEBACK: next_state = bus.intr ? ST_INTR : ST_FETCH;
            ST_INTR:      next_state = ST_FETCH;
            default:      next_state = ST_INIT;
        endcase
    end

    // RST masks every strobe in the same cycle so an aborted instruction never commits.
    always_comb begin
        ctrl = '0;
        if (!RST) begin
            case (state)
                ST_FETCH: ctrl.mem_rden1 = 1'b1;
                ST_EXEC:  ctrl = exec_ctrl;
                ST_WRITEBACK: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.rf_wr_sel = RF_MEM;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_PLUS4;
                end
                ST_INTR: begin
                    ctrl.int_taken = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_MTVEC;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.reg_write    = ctrl.reg_write;
    assign bus.mem_we2      = ctrl.mem_we2;
    assign bus.mem_rden1    = ctrl.mem_rden1;
    assign bus.mem_rden2    = ctrl.mem_rden2;
    assign bus.alu_fun      = ctrl.alu_fun;
    assign bus.alu_srcA_sel = ctrl.alu_srcA_sel;
    assign bus.alu_srcB_sel = ctrl.alu_srcB_sel;
    assign bus.pc_source    = ctrl.pc_source;
    assign bus.rf_wr_sel    = ctrl.rf_wr_sel;
    assign bus.csr_we       = ctrl.csr_we;
    assign bus.int_taken    = ctrl.int_taken;
    assign bus.mret_exec    = ctrl.mret_exec;

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// Self-checking bench for otter_ctrl_unit: directed cases plus random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_otter_ctrl_unit;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_WB    = 3;
    localparam int P_INTR  = 4;

    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   fail_count  = 0;

    always #5 clk = ~clk;

    otter_ctrl_unit_if bus ();

    otter_ctrl_unit u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic string phase_name(input int phase);
        case (phase)
            P_FETCH: return "FETCH";
            P_EXEC:  return "EXEC";
            P_WB:    return "WB";
            P_INTR:  return "INTR";
            default: return "IDLE";
        endcase
    endfunction

    // Output word order: pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, alu_fun,
    // srcA, srcB, pc_source, rf_wr_sel, csr_we, int_taken, mret_exec.
    function automatic logic [21:0] sample_outputs();
        return {bus.pc_write, bus.reg_write, bus.mem_we2, bus.mem_rden1, bus.mem_rden2,
                bus.alu_fun, bus.alu_srcA_sel, bus.alu_srcB_sel, bus.pc_source,
                bus.rf_wr_sel, bus.csr_we, bus.int_taken, bus.mret_exec};
    endfunction

    // Reference: what the datapath should see in a given phase of an instruction whose
    // source operands are a and b (branch outcome is computed from the operands).
    function automatic logic [21:0] model_out(input int phase, input logic [31:0] instr,
                                              input logic [31:0] a, input logic [31:0] b);
        logic       pcw, rw, we2, rd1, rd2, csrw, intt, mret, taken;
        logic [3:0] fun;
        logic [1:0] sa, rs;
        logic [2:0] sb, ps, f3;
        logic [6:0] op;
        {pcw, rw, we2, rd1, rd2, csrw, intt, mret} = '0;
        fun = 4'd0; sa = 2'd0; rs = 2'd0; sb = 3'd0; ps = 3'd0;
        op  = instr[6:0];
        f3  = instr[14:12];
        case (phase)
            P_FETCH: rd1 = 1'b1;
            P_WB:    begin rw = 1'b1; rs = 2'd2; pcw = 1'b1; end
            P_INTR:  begin intt = 1'b1; pcw = 1'b1; ps = 3'd4; end
            P_EXEC: begin
                pcw = 1'b1;
                if (op == 7'b0000011) begin
                    pcw = 1'b0; rd2 = 1'b1; sb = 3'd1;
                end else if (op == 7'b0110011) begin
                    fun = {instr[30], f3}; rw = 1'b1; rs = 2'd3;
                end else if (op == 7'b0010011) begin
                    fun = {(f3 == 3'd5) && instr[30], f3}; sb = 3'd1; rw = 1'b1; rs = 2'd3;
                end else if (op == 7'b0110111) begin
                    fun = 4'b1001; sa = 2'd1; rw = 1'b1; rs = 2'd3;
                end else if (op == 7'b0010111) begin
                    sa = 2'd1; sb = 3'd3; rw = 1'b1; rs = 2'd3;
                end else if (op == 7'b0100011) begin
                    sb = 3'd2; we2 = 1'b1;
                end else if (op == 7'b1101111) begin
                    ps = 3'd3; rw = 1'b1;
                end else if (op == 7'b1100111) begin
                    ps = 3'd1; rw = 1'b1;
                end else if (op == 7'b1100011) begin
                    case (f3)
                        3'd0:    taken = (a == b);
                        3'd1:    taken = (a != b);
                        3'd4:    taken = ($signed(a) <  $signed(b));
                        3'd5:    taken = ($signed(a) >= $signed(b));
                        3'd6:    taken = (a <  b);
                        3'd7:    taken = (a >= b);
                        default: taken = 1'b0;
                    endcase
                    ps = taken ? 3'd2 : 3'd0;
                end else if (op == 7'b1110011) begin
                    if (f3 == 3'd0 && instr[31:20] == 12'h302) begin
                        ps = 3'd5; mret = 1'b1;
                    end else if (f3 == 3'd1) begin
                        fun = 4'b1001; csrw = 1'b1; rw = 1'b1; rs = 2'd1;
                    end else if (f3 == 3'd2) begin
                        fun = 4'b0110; sb = 3'd4; csrw = 1'b1; rw = 1'b1; rs = 2'd1;
                    end else if (f3 == 3'd3) begin
                        fun = 4'b0111; sa = 2'd2; sb = 3'd4; csrw = 1'b1; rw = 1'b1; rs = 2'd1;
                    end
                end
            end
            default: ;
        endcase
        return {pcw, rw, we2, rd1, rd2, fun, sa, sb, ps, rs, csrw, intt, mret};
    endfunction

    task automatic checkOutput(input string tag, input logic [21:0] got, input logic [21:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                                 input logic [31:0] b, input logic irq, input logic rst_v);
        rst        = rst_v;
        bus.ir     = instr;
        bus.br_eq  = (a == b);
        bus.br_lt  = ($signed(a) < $signed(b));
        bus.br_ltu = (a < b);
        bus.intr   = irq;
    endtask

    task automatic checkCycle(input string tag, input logic [21:0] exp);
        @(negedge clk);
        checkOutput(tag, sample_outputs(), exp);
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to its last cycle, plus the INTR cycle if irq is held
    // at the boundary. With noisy set, intr toggles randomly before the boundary.
    task automatic doInstr(input string tag, input logic [31:0] instr, input logic [31:0] a,
                           input logic [31:0] b, input logic irq, input logic noisy);
        int          phases[$];
        logic [31:0] shown;
        logic        early;
        phases.push_back(P_FETCH);
        phases.push_back(P_EXEC);
        if (instr[6:0] == 7'b0000011) phases.push_back(P_WB);
        foreach (phases[i]) begin
            shown = (phases[i] == P_FETCH) ? $urandom : instr;
            early = noisy ? 1'($urandom_range(0, 1)) : irq;
            applyStimulus(shown, a, b, (i == phases.size() - 1) ? irq : early, 1'b0);
            checkCycle($sformatf("%s.%s", tag, phase_name(phases[i])),
                       model_out(phases[i], instr, a, b));
        end
        if (irq) begin
            applyStimulus(instr, a, b, 1'($urandom_range(0, 1)), 1'b0);
            checkCycle($sformatf("%s.%s", tag, phase_name(P_INTR)), model_out(P_INTR, instr, a, b));
        end
    endtask

    function automatic logic [31:0] random_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:       r[6:0] = 7'b0110011;
            1:       r[6:0] = 7'b0010011;
            2:       r[6:0] = 7'b0110111;
            3:       r[6:0] = 7'b0010111;
            4:       r[6:0] = 7'b0100011;
            5:       r[6:0] = 7'b1101111;
            6:       r[6:0] = 7'b1100111;
            7:       r[6:0] = 7'b1100011;
            8:       r[6:0] = 7'b1110011;
            9:       r[6:0] = 7'b0000011;
            default: ;
        endcase
        if (r[6:0] == 7'b1110011 && $urandom_range(0, 2) == 0) begin
            r[31:20] = 12'h302;
            r[14:12] = 3'b000;
        end
        return r;
    endfunction

    initial begin
        logic [31:0] a, b, instr;
        logic        irq;

        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            checkCycle("reset", model_out(P_IDLE, 32'd0, 32'd0, 32'd0));
        end
        applyStimulus($urandom, 32'd0, 32'd0, 1'b0, 1'b0);
        checkCycle("init", model_out(P_IDLE, 32'd0, 32'd0, 32'd0));

        doInstr("sub",    32'h402081B3, 32'd7, 32'd3, 1'b0, 1'b0);
        doInstr("srai",   32'h4032D293, 32'd7, 32'd3, 1'b0, 1'b0);
        doInstr("lw",     32'h0000A283, 32'd7, 32'd3, 1'b0, 1'b0);
        doInstr("beq_t",  32'h00208463, 32'd9, 32'd9, 1'b0, 1'b0);
        doInstr("beq_nt", 32'h00208463, 32'd9, 32'd4, 1'b0, 1'b0);
        doInstr("bgeu_t", 32'h0020F463, 32'd5, 32'd3, 1'b0, 1'b0);
        doInstr("add_irq", 32'h002081B3, 32'd1, 32'd2, 1'b1, 1'b0);
        doInstr("mret",   32'h30200073, 32'd1, 32'd2, 1'b0, 1'b0);
        doInstr("lui",    32'h123452B7, 32'd1, 32'd2, 1'b0, 1'b0);
        doInstr("lw_irq", 32'h0000A283, 32'd1, 32'd2, 1'b1, 1'b1);

        // Reset landing on the writeback cycle of a load must suppress the register write.
        applyStimulus($urandom, 32'd0, 32'd0, 1'b0, 1'b0);
        checkCycle("lwrst.FETCH", model_out(P_FETCH, 32'h0000A283, 32'd0, 32'd0));
        applyStimulus(32'h0000A283, 32'd0, 32'd0, 1'b0, 1'b0);
        checkCycle("lwrst.EXEC", model_out(P_EXEC, 32'h0000A283, 32'd0, 32'd0));
        applyStimulus(32'h0000A283, 32'd0, 32'd0, 1'b1, 1'b1);
        checkCycle("lwrst.WB", model_out(P_IDLE, 32'd0, 32'd0, 32'd0));
        applyStimulus(32'h0000A283, 32'd0, 32'd0, 1'b1, 1'b0);
        checkCycle("lwrst.INIT", model_out(P_IDLE, 32'd0, 32'd0, 32'd0));

        for (int n = 0; n < 300; n++) begin
            instr = random_instr();
            a     = $urandom;
            b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
            irq   = ($urandom_range(0, 4) == 0);
            doInstr($sformatf("rand%0d", n), instr, a, b, irq, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
